pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the decode stage of the RV32I core.
- Watches the instruction in ID (register addresses, usage flags, halt) and the instruction in EX (load, destination, redirect).
- Issues stall, flush, bubble and freeze controls to the PC, IF/ID and ID/EX registers.
- Sequences halt: drains the pipeline, then asserts a sticky halt.
- Keeps a saturating stall-cycle performance counter.

Parameters:
DRAIN_CYCLES, 3, cycles spent in DRAIN, excluding freeze cycles, before halt is asserted; legal range 1 to 15.
CNT_W, 16, width of the stall-cycle counter.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst  in  1  reset, asynchronous, active-low.
i_id_valid  in  1  ID holds a real instruction.
i_id_rs1  in  5  rs1 address of the ID instruction.
i_id_rs2  in  5  rs2 address of the ID instruction.
i_id_uses_rs1  in  1  ID instruction reads rs1, per its format.
i_id_uses_rs2  in  1  ID instruction reads rs2, per its format.
i_id_halt  in  1  ID instruction is halt.
i_ex_valid  in  1  EX holds a real instruction.
i_ex_rd  in  5  destination register of the EX instruction.
i_ex_dmem_rd_en  in  1  EX instruction is a load.
i_ex_redirect  in  1  EX resolved a taken branch or jump.
i_dmem_wait  in  1  data memory not ready.
o_if_stall  out  1  PC holds its value.
o_id_stall  out  1  IF/ID register holds its value.
o_if_flush  out  1  IF/ID register loads a bubble.
o_ex_bubble  out  1  ID/EX register loads a bubble.
o_pipe_freeze  out  1  every pipeline register holds.
o_halt  out  1  core halted; sticky.
o_state  out  2  current state: RUN=0, DRAIN=1, HALTED=2.
o_stall_cnt  out  CNT_W  count of stall and freeze cycles.

Behaviour:
- Reset (i_rst low, asynchronous): state=RUN, drain counter=0, o_stall_cnt=0, o_halt=0. Reset asserted in any state, including mid-DRAIN, returns to RUN immediately.
- Output timing: control outputs are combinational (Mealy) on the current state and inputs. o_halt and o_state decode the registered state. Any output not named for a case below is 0.
- Load-use hazard (lu) is true when all hold:
  - i_id_valid, i_ex_valid and i_ex_dmem_rd_en are high;
  - i_ex_rd is not 0;
  - (i_id_uses_rs1 and i_id_rs1 equals i_ex_rd) or (i_id_uses_rs2 and i_id_rs2 equals i_ex_rd).
  - Register x0 never creates a hazard.
- RUN, one priority case per cycle:
  1. i_dmem_wait: o_pipe_freeze=1. A pending redirect is deferred; EX holds it.
  2. i_ex_redirect: o_if_flush=1, o_ex_bubble=1. Any ID halt or lu is discarded. Stay in RUN.
  3. lu: o_if_stall=1, o_id_stall=1, o_ex_bubble=1 for exactly one cycle. Stay in RUN; the load then forwards from MEM.
  4. i_id_valid and i_id_halt: no stall this cycle, so halt advances to EX. Next state DRAIN, drain counter loaded with DRAIN_CYCLES.
- DRAIN:
  - Every cycle: o_if_stall=1, o_if_flush=1, o_ex_bubble=1.
  - If i_dmem_wait: o_pipe_freeze=1 and the counter holds.
  - Else if i_ex_redirect (an older instruction redirects, so the halt was wrong-path): next state RUN, counter cleared; the flush outputs above already cover this cycle.
  - Else the counter decrements. When it decrements from 1, next state is HALTED.
  - With no wait, DRAIN lasts exactly DRAIN_CYCLES cycles.
- HALTED: o_halt=1, o_if_stall=1, o_if_flush=1, o_ex_bubble=1. All inputs are ignored; only reset exits.
- o_stall_cnt increments on any cycle in RUN or DRAIN where o_if_stall or o_pipe_freeze is 1. It saturates at all-ones and never wraps. It is frozen in HALTED.

Test Plan:
- Load-use: EX lw with rd=5, ID add with rs2=5 and uses_rs2=1 → one cycle of o_if_stall=o_id_stall=o_ex_bubble=1; next cycle all 0; o_stall_cnt=1.
- x0 and unused operand: EX load rd=0 with ID rs1=0 → no stall. EX load rd=7 with ID rs2=7 but uses_rs2=0 → no stall.
- Priority: i_ex_redirect, lu and i_id_halt in the same cycle → only o_if_flush=o_ex_bubble=1; state stays RUN. Add i_dmem_wait in the same cycle → only o_pipe_freeze=1.
- Halt drain: halt in ID → DRAIN for exactly 3 cycles → o_halt=1 and o_state=2 on the 4th edge. One i_dmem_wait cycle mid-DRAIN delays o_halt by one cycle.
- Wrong-path halt: i_ex_redirect in the 2nd DRAIN cycle → o_state=0 next cycle, o_halt stays 0.
- Reset and saturation: reset low mid-DRAIN → o_state=0, o_stall_cnt=0 at once. With CNT_W=4, 20 freeze cycles → o_stall_cnt=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-stage sequencing bus: hazard-relevant fields of the ID and EX
// instructions, plus the stall/flush/bubble/freeze controls returned to the pipe.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             i_id_valid;
  logic [4:0]       i_id_rs1;
  logic [4:0]       i_id_rs2;
  logic             i_id_uses_rs1;
  logic             i_id_uses_rs2;
  logic             i_id_halt;
  logic             i_ex_valid;
  logic [4:0]       i_ex_rd;
  logic             i_ex_dmem_rd_en;
  logic             i_ex_redirect;
  logic             i_dmem_wait;
  logic             o_if_stall;
  logic             o_id_stall;
  logic             o_if_flush;
  logic             o_ex_bubble;
  logic             o_pipe_freeze;
  logic             o_halt;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_stall_cnt;

  // Pipeline side: presents instruction info, receives controls.
  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
           i_id_halt, i_ex_valid, i_ex_rd, i_ex_dmem_rd_en, i_ex_redirect,
           i_dmem_wait,
    input  o_if_stall, o_id_stall, o_if_flush, o_ex_bubble, o_pipe_freeze,
           o_halt, o_state, o_stall_cnt
  );

  // Controller side.
  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
           i_id_halt, i_ex_valid, i_ex_rd, i_ex_dmem_rd_en, i_ex_redirect,
           i_dmem_wait,
    output o_if_stall, o_id_stall, o_if_flush, o_ex_bubble, o_pipe_freeze,
           o_halt, o_state, o_stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage sequencing controller for the RV32I pipeline: load-use
// interlock, redirect flush, memory-wait freeze, halt drain and a saturating
// stall-cycle counter. Controls are Mealy on the registered state.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_e           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu;
  logic rs1_hit, rs2_hit;
  logic if_stall, id_stall, if_flush, ex_bubble, freeze;

  // Counter never wraps: once all-ones it stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Load-use detection; x0 is never a real dependency.
  always_comb begin
    rs1_hit = bus.i_id_uses_rs1 && (bus.i_id_rs1 == bus.i_ex_rd);
    rs2_hit = bus.i_id_uses_rs2 && (bus.i_id_rs2 == bus.i_ex_rd);
    lu      = bus.i_id_valid && bus.i_ex_valid && bus.i_ex_dmem_rd_en &&
              (bus.i_ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

  // Per-state control decode and next-state / counter computation.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    stall_cnt_d = stall_cnt_q;
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    if_flush    = 1'b0;
    ex_bubble   = 1'b0;
    freeze      = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.i_dmem_wait) begin
          // Whole pipe holds, so an EX redirect stays in EX for later.
          freeze = 1'b1;
        end else if (bus.i_ex_redirect) begin
          // Wrong-path ID instruction is dropped, including any halt or lu.
          if_flush  = 1'b1;
          ex_bubble = 1'b1;
        end else if (lu) begin
          // One bubble; afterwards the load value forwards from MEM.
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_bubble = 1'b1;
        end else if (bus.i_id_valid && bus.i_id_halt) begin
          // Halt moves into EX this cycle; stop fetching behind it.
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if_stall  = 1'b1;
        if_flush  = 1'b1;
        ex_bubble = 1'b1;
        if (bus.i_dmem_wait) begin
          freeze = 1'b1;
        end else if (bus.i_ex_redirect) begin
          // An older instruction redirected: the halt was speculative.
          state_d = RUN;
          drain_d = 4'd0;
        end else begin
          drain_d = drain_q - 4'd1;
          if (drain_q == 4'd1) begin
            state_d = HALTED;
          end
        end
      end
      HALTED: begin
        if_stall  = 1'b1;
        if_flush  = 1'b1;
        ex_bubble = 1'b1;
      end
      default: begin
        state_d = RUN;
        drain_d = 4'd0;
      end
    endcase

    if ((state_q != HALTED) && (if_stall || freeze)) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  // State, drain counter and performance counter registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= RUN;
      drain_q     <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.o_if_stall    = if_stall;
  assign bus.o_id_stall    = id_stall;
  assign bus.o_if_flush    = if_flush;
  assign bus.o_ex_bubble   = ex_bubble;
  assign bus.o_pipe_freeze = freeze;
  assign bus.o_halt        = (state_q == HALTED);
  assign bus.o_state       = state_q;
  assign bus.o_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios followed by
// random traffic, checked against a behavioural model of the controller.
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;
  localparam int DC = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       rst_n;
    logic       idv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       hlt;
    logic       exv;
    logic [4:0] rd;
    logic       ld;
    logic       redir;
    logic       wt;
  } stim_t;

  // ctrl = {if_stall, id_stall, if_flush, ex_bubble, pipe_freeze, halt}
  typedef struct packed {
    logic [5:0]    ctrl;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   cyc_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Reference model state: mode 0=RUN 1=DRAIN 2=HALTED.
  int m_state = 0;
  int m_drain = 0;
  int m_cnt   = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim(input int mode);
    stim_t s;
    s.rst_n = !(($urandom_range(0, 59) == 0) ||
                ((mode == 2) && ($urandom_range(0, 3) == 0)));
    s.idv   = ($urandom_range(0, 3) != 0);
    s.rs1   = 5'($urandom_range(0, 3));
    s.rs2   = 5'($urandom_range(0, 3));
    s.u1    = 1'($urandom_range(0, 1));
    s.u2    = 1'($urandom_range(0, 1));
    s.hlt   = ($urandom_range(0, 11) == 0);
    s.exv   = ($urandom_range(0, 3) != 0);
    s.rd    = 5'($urandom_range(0, 3));
    s.ld    = 1'($urandom_range(0, 1));
    s.redir = ($urandom_range(0, 7) == 0);
    s.wt    = ($urandom_range(0, 5) == 0);
    return s;
  endfunction

  // Expected response for one cycle, then advance the model across the edge.
  function automatic exp_t model_step(input stim_t s);
    exp_t e;
    bit   lu;
    bit   stall, frz;
    int   nst, nd;
    if (!s.rst_n) begin
      m_state = 0;
      m_drain = 0;
      m_cnt   = 0;
    end
    e.st  = 2'(m_state);
    e.cnt = CW'(m_cnt);
    lu = s.idv && s.exv && s.ld && (s.rd != 0) &&
         ((s.u1 && (s.rs1 == s.rd)) || (s.u2 && (s.rs2 == s.rd)));
    nst = m_state;
    nd  = m_drain;
    if (m_state == 0) begin
      if (s.wt)                 e.ctrl = 6'b000010;
      else if (s.redir)         e.ctrl = 6'b001100;
      else if (lu)              e.ctrl = 6'b110100;
      else begin
        e.ctrl = 6'b000000;
        if (s.idv && s.hlt) begin
          nst = 1;
          nd  = DC;
        end
      end
    end else if (m_state == 1) begin
      e.ctrl = s.wt ? 6'b101110 : 6'b101100;
      if (!s.wt) begin
        if (s.redir) begin
          nst = 0;
          nd  = 0;
        end else begin
          nd = m_drain - 1;
          if (nd == 0) nst = 2;
        end
      end
    end else begin
      e.ctrl = 6'b101101;
    end
    stall = e.ctrl[5];
    frz   = e.ctrl[1];
    if (s.rst_n) begin
      if ((m_state != 2) && (stall || frz) && (m_cnt < CMAX)) m_cnt = m_cnt + 1;
      m_state = nst;
      m_drain = nd;
    end
    return e;
  endfunction

  task automatic apply(input stim_t s);
    @(posedge clk);
    #1;
    rst_n               = s.rst_n;
    bus.i_id_valid      = s.idv;
    bus.i_id_rs1        = s.rs1;
    bus.i_id_rs2        = s.rs2;
    bus.i_id_uses_rs1   = s.u1;
    bus.i_id_uses_rs2   = s.u2;
    bus.i_id_halt       = s.hlt;
    bus.i_ex_valid      = s.exv;
    bus.i_ex_rd         = s.rd;
    bus.i_ex_dmem_rd_en = s.ld;
    bus.i_ex_redirect   = s.redir;
    bus.i_dmem_wait     = s.wt;
    q.push_back(model_step(s));
    cyc_q.push_back(cyc);
    cyc = cyc + 1;
  endtask

  task automatic apply_n(input stim_t s, input int n);
    for (int i = 0; i < n; i++) apply(s);
  endtask

  // Monitor: the controller presents a response every cycle.
  initial begin : monitor
    exp_t       e;
    int         c;
    logic [5:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        c = cyc_q.pop_front();
        got = {bus.o_if_stall, bus.o_id_stall, bus.o_if_flush,
               bus.o_ex_bubble, bus.o_pipe_freeze, bus.o_halt};
        checks = checks + 1;
        if (got !== e.ctrl) begin
          errors = errors + 1;
          $display("FAIL ctrl cyc=%0d got=%b exp=%b", c, got, e.ctrl);
        end
        checks = checks + 1;
        if (bus.o_state !== e.st) begin
          errors = errors + 1;
          $display("FAIL state cyc=%0d got=%0d exp=%0d", c, bus.o_state, e.st);
        end
        checks = checks + 1;
        if (bus.o_stall_cnt !== e.cnt) begin
          errors = errors + 1;
          $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", c, bus.o_stall_cnt, e.cnt);
        end
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    s = idle();
    bus.i_id_valid = 0; bus.i_id_rs1 = 0; bus.i_id_rs2 = 0;
    bus.i_id_uses_rs1 = 0; bus.i_id_uses_rs2 = 0; bus.i_id_halt = 0;
    bus.i_ex_valid = 0; bus.i_ex_rd = 0; bus.i_ex_dmem_rd_en = 0;
    bus.i_ex_redirect = 0; bus.i_dmem_wait = 0;

    // Reset state
    s = idle(); s.rst_n = 1'b0;
    apply_n(s, 2);
    apply(idle());

    // Load-use on rs2, then clear pipe
    s = idle(); s.exv = 1; s.ld = 1; s.rd = 5; s.idv = 1; s.rs2 = 5; s.u2 = 1;
    apply(s);
    apply_n(idle(), 2);

    // x0 destination and unused operand never stall
    s = idle(); s.exv = 1; s.ld = 1; s.rd = 0; s.idv = 1; s.rs1 = 0; s.u1 = 1;
    apply(s);
    s = idle(); s.exv = 1; s.ld = 1; s.rd = 7; s.idv = 1; s.rs2 = 7; s.u2 = 0;
    apply(s);

    // Priority: redirect over lu and halt; wait over everything
    s = idle(); s.exv = 1; s.ld = 1; s.rd = 3; s.idv = 1; s.rs1 = 3; s.u1 = 1;
    s.hlt = 1; s.redir = 1;
    apply(s);
    s.wt = 1;
    apply(s);
    apply(idle());

    // Halt drain with no wait
    s = idle(); s.idv = 1; s.hlt = 1;
    apply(s);
    apply_n(idle(), 5);
    s = idle(); s.rst_n = 0; apply(s);
    apply(idle());

    // Halt drain with one wait cycle in the middle
    s = idle(); s.idv = 1; s.hlt = 1;
    apply(s);
    apply(idle());
    s = idle(); s.wt = 1; apply(s);
    apply_n(idle(), 4);
    s = idle(); s.rst_n = 0; apply(s);
    apply(idle());

    // Wrong-path halt: redirect in second drain cycle
    s = idle(); s.idv = 1; s.hlt = 1;
    apply(s);
    apply(idle());
    s = idle(); s.redir = 1; apply(s);
    apply_n(idle(), 2);

    // Reset mid-drain
    s = idle(); s.idv = 1; s.hlt = 1;
    apply(s);
    apply(idle());
    s = idle(); s.rst_n = 0; apply(s);
    apply(idle());

    // Counter saturation: 20 freeze cycles
    s = idle(); s.wt = 1;
    apply_n(s, 20);
    apply_n(idle(), 2);
    s = idle(); s.rst_n = 0; apply(s);

    // Random traffic
    for (int i = 0; i < 1500; i++) apply(rand_stim(m_state));

    repeat (2) @(negedge clk);
    #1;
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain_queue got=%0d left exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
